// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake between the arbiter and a UART TX serializer.
// Arbiter drives start/data; the serializer answers with a done pulse.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ producers.
// Each grant sends an optional tag byte followed by the requester's byte.
module uart_tx_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TAG_EN      = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_data,
    output logic [N_REQ-1:0]          o_ack,
    output logic [$clog2(N_REQ)-1:0]  o_grant_id,
    output logic                      o_busy,
    output logic                      o_err,
    uart_tx_arbiter_if.master         tx
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [DATA_W-1:0] TAG_BASE =
        (DATA_W == 8) ? DATA_W'(8'hA0) : '0;

    typedef enum logic [2:0] {
        IDLE,
        START_TAG,
        WAIT_TAG,
        START_DATA,
        WAIT_DATA
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    last_q, last_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [DATA_W-1:0] byte_q, byte_d;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic              start_q, start_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              pick_vld;
    logic [IDW-1:0]    pick_idx;
    logic [DATA_W-1:0] pick_byte;
    logic              to_hit;

    function automatic logic [DATA_W-1:0] tag_byte(
        input logic [IDW-1:0] id
    );
        return TAG_BASE | DATA_W'(id);
    endfunction

    // Scan from the requester after the last one served, with wrap.
    always_comb begin
        logic [IDW-1:0] k;
        k        = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = IDW'((int'(last_q) + i) % N_REQ);
            if (!pick_vld && i_req[k]) begin
                pick_vld = 1'b1;
                pick_idx = k;
            end
        end
    end

    assign pick_byte = i_data[pick_idx*DATA_W +: DATA_W];

    // cnt_q counts completed waiting cycles in the current WAIT state.
    assign to_hit = (TIMEOUT_CYC > 0) &&
                    (int'(cnt_q) + 1 >= TIMEOUT_CYC);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        byte_d  = byte_q;
        txd_d   = txd_q;
        start_d = 1'b0;
        ack_d   = '0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    byte_d  = pick_byte;
                    ack_d   = N_REQ'(1) << pick_idx;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    if (TAG_EN != 0) begin
                        state_d = START_TAG;
                        txd_d   = tag_byte(pick_idx);
                    end else begin
                        state_d = START_DATA;
                        txd_d   = pick_byte;
                    end
                end
            end
            START_TAG: begin
                state_d = WAIT_TAG;
                cnt_d   = '0;
            end
            WAIT_TAG: begin
                if (tx.tx_done) begin
                    state_d = START_DATA;
                    start_d = 1'b1;
                    txd_d   = byte_q;
                end else if (to_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    last_d  = grant_q;
                end else if (TIMEOUT_CYC > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START_DATA: begin
                state_d = WAIT_DATA;
                cnt_d   = '0;
            end
            WAIT_DATA: begin
                if (tx.tx_done) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (to_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    last_d  = grant_q;
                end else if (TIMEOUT_CYC > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(N_REQ - 1);
            grant_q <= '0;
            byte_q  <= '0;
            txd_q   <= '0;
            start_q <= 1'b0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            byte_q  <= byte_d;
            txd_q   <= txd_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_ack       = ack_q;
    assign o_grant_id  = grant_q;
    assign o_busy      = busy_q;
    assign o_err       = err_q;
    assign tx.tx_start = start_q;
    assign tx.tx_data  = txd_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter in three configurations:
// tagged, untagged, and tagged with a 20-cycle done timeout.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] data = '0;
    logic        done = 1'b0;
    int          sel = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.DATA_W(8)) if_a ();
    uart_tx_arbiter_if #(.DATA_W(8)) if_b ();
    uart_tx_arbiter_if #(.DATA_W(8)) if_c ();

    logic [3:0] a_ack, b_ack, c_ack;
    logic [1:0] a_gnt, b_gnt, c_gnt;
    logic       a_busy, b_busy, c_busy;
    logic       a_err, b_err, c_err;

    assign if_a.tx_done = done && (sel == 0);
    assign if_b.tx_done = done && (sel == 1);
    assign if_c.tx_done = done && (sel == 2);

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_W(8), .TAG_EN(1), .TIMEOUT_CYC(0)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .o_ack(a_ack), .o_grant_id(a_gnt), .o_busy(a_busy),
        .o_err(a_err), .tx(if_a)
    );

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_W(8), .TAG_EN(0), .TIMEOUT_CYC(0)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .o_ack(b_ack), .o_grant_id(b_gnt), .o_busy(b_busy),
        .o_err(b_err), .tx(if_b)
    );

    uart_tx_arbiter #(
        .N_REQ(4), .DATA_W(8), .TAG_EN(1), .TIMEOUT_CYC(20)
    ) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
        .o_ack(c_ack), .o_grant_id(c_gnt), .o_busy(c_busy),
        .o_err(c_err), .tx(if_c)
    );

    logic [3:0] o_ack;
    logic [1:0] o_gnt;
    logic       o_busy, o_err, o_start;
    logic [7:0] o_txd;

    always_comb begin
        o_ack = a_ack; o_gnt = a_gnt; o_busy = a_busy;
        o_err = a_err; o_start = if_a.tx_start; o_txd = if_a.tx_data;
        case (sel)
            1: begin
                o_ack = b_ack; o_gnt = b_gnt; o_busy = b_busy;
                o_err = b_err; o_start = if_b.tx_start;
                o_txd = if_b.tx_data;
            end
            2: begin
                o_ack = c_ack; o_gnt = c_gnt; o_busy = c_busy;
                o_err = c_err; o_start = if_c.tx_start;
                o_txd = if_c.tx_data;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; done = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (o_start !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(tag, 32'(o_start), 32'd1);
    endtask

    // Done arrives n cycles after the start edge; no start in between.
    task automatic pulse_done(input int n, input string tag);
        int extra = 0;
        repeat (n - 1) begin
            step();
            if (o_start) extra++;
        end
        done = 1'b1;
        step();
        done = 1'b0;
        chk(tag, 32'(extra), 32'd0);
    endtask

    initial begin
        int n;
        int extra;
        int exp;

        // single tagged requester
        sel = 0;
        do_reset();
        chk("rst_ack", 32'(o_ack), 32'h0);
        chk("rst_start", 32'(o_start), 32'h0);
        chk("rst_txd", 32'(o_txd), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_gnt", 32'(o_gnt), 32'h0);
        chk("rst_err", 32'(o_err), 32'h0);
        data = 32'h0000_0000;
        data[23:16] = 8'h5A;
        req = 4'b0100;
        wait_start("t1_start_tag");
        chk("t1_ack", 32'(o_ack), 32'h4);
        chk("t1_tag", 32'(o_txd), 32'hA2);
        chk("t1_gnt", 32'(o_gnt), 32'h2);
        chk("t1_busy", 32'(o_busy), 32'h1);
        req = '0;
        pulse_done(10, "t1_gap_tag");
        chk("t1_start_data", 32'(o_start), 32'h1);
        chk("t1_data", 32'(o_txd), 32'h5A);
        chk("t1_ack_once", 32'(o_ack), 32'h0);
        repeat (9) step();
        chk("t1_busy_wait", 32'(o_busy), 32'h1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t1_busy_fall", 32'(o_busy), 32'h0);
        chk("t1_txd_hold", 32'(o_txd), 32'h5A);

        // all four requesting: order 0,1,2,3,0
        do_reset();
        data = 32'h4433_2211;
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp = g % 4;
            wait_start($sformatf("t2_start_tag%0d", g));
            chk($sformatf("t2_ack%0d", g), 32'(o_ack), 32'(1 << exp));
            chk($sformatf("t2_gnt%0d", g), 32'(o_gnt), 32'(exp));
            chk($sformatf("t2_tag%0d", g), 32'(o_txd), 32'(8'hA0 + exp));
            pulse_done(3, $sformatf("t2_gap_tag%0d", g));
            chk($sformatf("t2_start_data%0d", g), 32'(o_start), 32'h1);
            chk($sformatf("t2_data%0d", g), 32'(o_txd),
                32'(8'h11 * (exp + 1)));
            chk($sformatf("t2_ack_once%0d", g), 32'(o_ack), 32'h0);
            pulse_done(3, $sformatf("t2_gap_data%0d", g));
        end
        req = '0;

        // untagged, requester 1 held high
        sel = 1;
        do_reset();
        data = '0;
        data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_start("t3_start");
        chk("t3_ack", 32'(o_ack), 32'h2);
        chk("t3_data", 32'(o_txd), 32'h3C);
        chk("t3_gnt", 32'(o_gnt), 32'h1);
        pulse_done(4, "t3_one_start");
        chk("t3_idle_start", 32'(o_start), 32'h0);
        chk("t3_idle_busy", 32'(o_busy), 32'h0);
        step();
        chk("t3_regrant_start", 32'(o_start), 32'h1);
        chk("t3_regrant_ack", 32'(o_ack), 32'h2);
        chk("t3_regrant_data", 32'(o_txd), 32'h3C);
        req = '0;

        // done timeout after 20 waiting cycles
        sel = 2;
        do_reset();
        data = '0;
        req = 4'b0011;
        wait_start("t4_start");
        chk("t4_gnt", 32'(o_gnt), 32'h0);
        chk("t4_tag", 32'(o_txd), 32'hA0);
        n = 0;
        extra = 0;
        while (o_err !== 1'b1 && n < 40) begin
            step();
            if (o_start) extra++;
            n++;
        end
        chk("t4_err_delay", 32'(n), 32'd21);
        chk("t4_err_idle", 32'(o_busy), 32'h0);
        chk("t4_no_start", 32'(extra), 32'h0);
        step();
        chk("t4_err_pulse", 32'(o_err), 32'h0);
        chk("t4_next_start", 32'(o_start), 32'h1);
        chk("t4_next_gnt", 32'(o_gnt), 32'h1);
        chk("t4_next_ack", 32'(o_ack), 32'h2);
        chk("t4_next_tag", 32'(o_txd), 32'hA1);
        req = '0;

        // spurious done in IDLE and START_DATA
        sel = 0;
        do_reset();
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t5_idle_busy", 32'(o_busy), 32'h0);
        chk("t5_idle_start", 32'(o_start), 32'h0);
        step();
        chk("t5_idle_busy2", 32'(o_busy), 32'h0);
        data = '0;
        data[7:0] = 8'h77;
        req = 4'b0001;
        wait_start("t5_start_tag");
        req = '0;
        pulse_done(2, "t5_gap_tag");
        chk("t5_start_data", 32'(o_start), 32'h1);
        chk("t5_data", 32'(o_txd), 32'h77);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("t5_sd_start", 32'(o_start), 32'h0);
        chk("t5_sd_busy", 32'(o_busy), 32'h1);
        repeat (3) step();
        chk("t5_still_wait", 32'(o_busy), 32'h1);
        chk("t5_no_extra", 32'(o_start), 32'h0);
        pulse_done(1, "t5_final");
        chk("t5_done_idle", 32'(o_busy), 32'h0);

        // async reset during WAIT_DATA
        do_reset();
        data = '0;
        data[31:24] = 8'h99;
        req = 4'b1000;
        wait_start("t6_start");
        chk("t6_gnt", 32'(o_gnt), 32'h3);
        req = '0;
        pulse_done(3, "t6_gap_tag");
        chk("t6_data", 32'(o_txd), 32'h99);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ack", 32'(o_ack), 32'h0);
        chk("t6_rst_start", 32'(o_start), 32'h0);
        chk("t6_rst_txd", 32'(o_txd), 32'h0);
        chk("t6_rst_busy", 32'(o_busy), 32'h0);
        chk("t6_rst_gnt", 32'(o_gnt), 32'h0);
        chk("t6_rst_err", 32'(o_err), 32'h0);
        req = 4'b1001;
        step();
        rst_n = 1'b1;
        wait_start("t6_post_start");
        chk("t6_post_gnt", 32'(o_gnt), 32'h0);
        chk("t6_post_ack", 32'(o_ack), 32'h1);
        chk("t6_post_tag", 32'(o_txd), 32'hA0);
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter between N_REQ byte producers. Arbitrates round-robin, optionally prepends a tag byte identifying the requester, and sequences the transmitter's start/done handshake. It sits between the producer blocks and the UART TX serializer, which runs off the baud-rate tick generator. Each grant emits one frame pair on the serial line: tag, then data.

## Interface
- N_REQ, 4: number of requesters; 2..16.
- DATA_W, 8: byte width.
- TAG_EN, 1: 1 = send tag byte before data byte; 0 = data byte only.
- TIMEOUT_CYC, 0: max i_clk cycles waited for i_tx_done per byte; 0 = wait forever.
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req  in  N_REQ  per-requester request; held high with data stable until its o_ack.
- i_data  in  N_REQ*DATA_W  flattened bytes; requester k at bits [k*DATA_W +: DATA_W].
- o_ack  out  N_REQ  one-hot, one-cycle pulse: requester's byte latched.
- o_tx_start  out  1  one-cycle pulse to the transmitter: send o_tx_data.
- o_tx_data  out  DATA_W  byte for the transmitter; stable from the start pulse until done.
- i_tx_done  in  1  one-cycle pulse from the transmitter: frame finished (stop bit sent).
- o_grant_id  out  $clog2(N_REQ)  index of the current or last granted requester.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  one-cycle pulse on a done timeout.

## Operation
- All outputs are registered. Reset value is 0 for every output. State = IDLE. Round-robin pointer last = N_REQ-1, so requester 0 wins first. Timeout counter = 0.
- States: IDLE, START_TAG, WAIT_TAG, START_DATA, WAIT_DATA.
- IDLE transition, when any i_req is high:
  - Select the first high request scanning from (last+1) mod N_REQ upward, with wrap.
  - Latch its i_data and index; set o_grant_id.
  - Pulse its o_ack.
  - Go to START_TAG if TAG_EN=1, else START_DATA.
- START_TAG:
  - o_tx_start=1 for this cycle only.
  - o_tx_data = tag byte: 0xA0 | grant index (low nibble = index, high nibble = 0xA for DATA_W=8; for other widths, index zero-extended).
  - Next state WAIT_TAG.
- WAIT_TAG: on i_tx_done go to START_DATA.
- START_DATA:
  - o_tx_start=1 for this cycle only.
  - o_tx_data = latched byte.
  - Next state WAIT_DATA.
- WAIT_DATA: on i_tx_done go to IDLE and set last = grant index.
- Timeout, when TIMEOUT_CYC>0:
  - The counter clears on entering each WAIT state and increments every WAIT cycle without i_tx_done.
  - When count reaches TIMEOUT_CYC: pulse o_err, go to IDLE, set last = grant index (the byte is dropped).
- i_tx_done outside the WAIT states is ignored.
- A request that drops before it is sampled in IDLE is never acked. Once acked, the transfer is committed regardless of i_req.
- A requester holding i_req high after its ack is treated as a new request. Its next request is served only after every other pending requester has had a turn.
- o_tx_data holds its value through the WAIT state and after returning to IDLE, until the next START state.
- Async reset mid-transfer aborts immediately to reset values. The transmitter may still finish a frame; its done pulse arrives in IDLE and is ignored.

## Timing
- Request sampled high at edge E (state IDLE). At edge E+1:
  - o_ack, o_busy=1, o_grant_id are valid.
  - o_tx_start is high with the tag byte (with TAG_EN=0, the data byte instead).
- o_ack and the first o_tx_start are coincident, each one cycle wide.
- i_tx_done at edge D in WAIT_TAG: o_tx_start for the data byte is high at edge D+1.
- i_tx_done at edge D in WAIT_DATA: state is IDLE at D+1 with o_busy=0. The earliest next grant's ack/start is at D+2.
- Minimum gap between frame pairs: one IDLE cycle.
- Timeout: o_err is high in the cycle after the TIMEOUT_CYC-th waiting cycle. The state is IDLE in that same cycle.

## Test plan
- Single requester 2, data 0x5A, TAG_EN=1, done 10 cycles after each start:
  - o_ack=4'b0100 and start with tx_data 0xA2 at the same edge.
  - Then start with 0x5A one cycle after the first done.
  - o_busy falls one cycle after the second done.
- All four requesting continuously with distinct bytes:
  - Grant order is 0,1,2,3,0.
  - Each o_ack is exactly one pulse per transfer; tx_data sequence is A0,d0,A1,d1,A2,d2,A3,d3.
- TAG_EN=0, requester 1 only:
  - Only one start per grant, carrying the data byte.
  - Back-to-back grants are separated by exactly one IDLE cycle.
- TIMEOUT_CYC=20, i_tx_done never asserted:
  - o_err pulses 21 cycles after the tag start; state returns to IDLE.
  - The next grant goes to the next requester in round-robin order.
- Spurious i_tx_done in IDLE and in START_DATA: no state change, no extra start.
- i_rst_n low during WAIT_DATA:
  - All outputs go to 0 immediately.
  - After release, the first grant goes to requester 0 even if requester 3 was being served.
